// File: rtl/delta_encoder.sv
// delta_encoder: frame-based signed first-difference encoder; define DELTA_CHECKSUM_EN to add a 32-bit frame checksum port
module delta_encoder #(
    parameter int SAMPLE_W  = 16,
    parameter int FRAME_LEN = 1024,
    parameter int CNT_W     = 10
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [SAMPLE_W-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [SAMPLE_W:0]   out_data,
    output logic                out_first,
    output logic                out_last,
    output logic                busy,
    output logic                done
`ifdef DELTA_CHECKSUM_EN
    ,
    output logic [31:0]         checksum
`endif
);
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
    state_t state, state_nx;
    logic [CNT_W-1:0] in_cnt;
    logic [SAMPLE_W-1:0] prev;
    logic acc, acc_last, clr;
    assign acc      = in_valid && in_ready;
    assign acc_last = acc && (in_cnt == CNT_W'(FRAME_LEN - 1));
    assign clr      = (state == IDLE) && start;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = start ? RUN : IDLE;
            RUN:     state_nx = acc_last ? DRAIN : RUN;
            DRAIN:   state_nx = (out_valid && out_ready && out_last) ? DONE : DRAIN;
            default: state_nx = IDLE;
        endcase
    end
    always_comb begin
        in_ready = (state == RUN) && (!out_valid || out_ready);
        busy     = (state == RUN) || (state == DRAIN);
        done     = (state == DONE);
    end
    // output register reloads on the same edge it handshakes, giving one word per clock
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_cnt    <= '0;
            prev      <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else if (clr) begin
            in_cnt    <= '0;
            prev      <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
        end else if (acc) begin
            in_cnt    <= in_cnt + CNT_W'(1);
            prev      <= in_data;
            out_valid <= 1'b1;
            out_data  <= (in_cnt == '0) ? {1'b0, in_data} : {1'b0, in_data} - {1'b0, prev};
            out_first <= (in_cnt == '0);
            out_last  <= acc_last;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end
`ifdef DELTA_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   checksum <= '0;
        else if (clr) checksum <= '0;
        else if (acc) checksum <= checksum + 32'(in_data);
    end
`endif
endmodule

// File: tb/tb_delta_encoder.sv
// tb_delta_encoder: directed self-checking bench for delta_encoder (FRAME_LEN=4, plus a 1024-sample checksum instance when DELTA_CHECKSUM_EN is defined)
module tb_delta_encoder;
    logic clk = 1'b0;
    logic rst_n, start, in_valid, in_ready, out_valid, out_ready, out_first, out_last, busy, done;
    logic [15:0] in_data;
    logic [16:0] out_data;
    int checks = 0;
    int errors = 0;
    logic [15:0] vin [4];
    logic [16:0] vexp [4];
`ifdef DELTA_CHECKSUM_EN
    logic [31:0] checksum;
    logic b_start, b_in_valid, b_in_ready, b_out_valid, b_out_first, b_out_last, b_busy, b_done;
    logic [15:0] b_in_data;
    logic [16:0] b_out_data;
    logic [31:0] b_checksum;
    logic b_out_ready;
`endif

    always #5 clk = ~clk;

    delta_encoder #(.SAMPLE_W(16), .FRAME_LEN(4), .CNT_W(2)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_first(out_first), .out_last(out_last), .busy(busy), .done(done)
`ifdef DELTA_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

`ifdef DELTA_CHECKSUM_EN
    delta_encoder #(.SAMPLE_W(16), .FRAME_LEN(1024), .CNT_W(10)) dut_big (
        .clk(clk), .rst_n(rst_n), .start(b_start), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .out_first(b_out_first), .out_last(b_out_last), .busy(b_busy), .done(b_done),
        .checksum(b_checksum)
    );
`endif

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        checks++;
        if ({in_ready, out_valid, out_data, out_first, out_last, busy, done} !== 23'd0) begin
            errors++;
            $display("FAIL reset outputs got %h exp 0", {in_ready, out_valid, out_data, out_first, out_last, busy, done});
        end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_ramp();
        vin  = '{16'd10, 16'd12, 16'd15, 16'd15};
        vexp = '{17'd10, 17'd2, 17'd3, 17'd0};
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({in_ready, busy} !== 2'b11) begin
            errors++;
            $display("FAIL ramp run_entry got %b exp 11", {in_ready, busy});
        end
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = vin[i];
            step();
            checks++;
            if ({out_valid, out_data, out_first, out_last} !== {1'b1, vexp[i], i == 0, i == 3}) begin
                errors++;
                $display("FAIL ramp word%0d got %h exp %h", i, {out_valid, out_data, out_first, out_last}, {1'b1, vexp[i], i == 0, i == 3});
            end
        end
        in_valid = 1'b0;
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL ramp early_done got %b exp 0", done);
        end
        step();
        checks++;
        if ({done, out_valid} !== 2'b10) begin
            errors++;
            $display("FAIL ramp done_pulse got %b exp 10", {done, out_valid});
        end
`ifdef DELTA_CHECKSUM_EN
        checks++;
        if (checksum !== 32'd52) begin
            errors++;
            $display("FAIL ramp checksum got %h exp %h", checksum, 32'd52);
        end
`endif
        step();
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL ramp done_clear got %b exp 00", {done, busy});
        end
    endtask

    task automatic test_negative();
        vin  = '{16'hFFFF, 16'h0000, 16'h0001, 16'hFFFF};
        vexp = '{17'h0FFFF, 17'h10001, 17'h00001, 17'h0FFFE};
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = vin[i];
            step();
            checks++;
            if ({out_valid, out_data, out_first, out_last} !== {1'b1, vexp[i], i == 0, i == 3}) begin
                errors++;
                $display("FAIL negative word%0d got %h exp %h", i, {out_valid, out_data, out_first, out_last}, {1'b1, vexp[i], i == 0, i == 3});
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL negative done got %b exp 1", done);
        end
        step();
    endtask

    task automatic test_backpressure();
        vin  = '{16'd100, 16'd110, 16'd105, 16'd200};
        vexp = '{17'd100, 17'd10, 17'h1FFFB, 17'd95};
        start = 1'b1;
        step();
        start = 1'b0;
        in_valid  = 1'b1;
        in_data   = vin[0];
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        in_data   = vin[1];
        for (int k = 0; k < 3; k++) begin
            step();
            checks++;
            if ({out_valid, out_data, out_first, in_ready} !== {1'b1, vexp[0], 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL backpressure hold%0d got %h exp %h", k, {out_valid, out_data, out_first, in_ready}, {1'b1, vexp[0], 1'b1, 1'b0});
            end
        end
        out_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            in_data = vin[i];
            step();
            checks++;
            if ({out_valid, out_data, out_first, out_last} !== {1'b1, vexp[i], 1'b0, i == 3}) begin
                errors++;
                $display("FAIL backpressure word%0d got %h exp %h", i, {out_valid, out_data, out_first, out_last}, {1'b1, vexp[i], 1'b0, i == 3});
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL backpressure done got %b exp 1", done);
        end
        step();
    endtask

    task automatic test_start_ignored();
        vin  = '{16'd7, 16'd9, 16'd4, 16'd4};
        vexp = '{17'd7, 17'd2, 17'h1FFFB, 17'd0};
        vexp[2] = 17'h1FFFB;
        in_valid = 1'b1;
        in_data  = vin[0];
        step();
        step();
        checks++;
        if ({in_ready, out_valid, busy} !== 3'b000) begin
            errors++;
            $display("FAIL idle_ignore got %b exp 000", {in_ready, out_valid, busy});
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL start_entry got %b exp 01", {out_valid, in_ready});
        end
        for (int i = 0; i < 4; i++) begin
            in_data = vin[i];
            start   = (i == 2);
            step();
            checks++;
            if ({out_valid, out_data, out_first, out_last} !== {1'b1, (i == 2) ? 17'h1FFFB : vexp[i], i == 0, i == 3}) begin
                errors++;
                $display("FAIL start_ignored word%0d got %h exp %h", i, {out_valid, out_data, out_first, out_last}, {1'b1, (i == 2) ? 17'h1FFFB : vexp[i], i == 0, i == 3});
            end
        end
        start    = 1'b0;
        in_valid = 1'b0;
        step();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL start_ignored done got %b exp 1", done);
        end
        step();
        step();
        checks++;
        if ({done, busy} !== 2'b00) begin
            errors++;
            $display("FAIL start_ignored extra_frame got %b exp 00", {done, busy});
        end
    endtask

    task automatic test_reset_mid();
        vin  = '{16'd50, 16'd51, 16'd52, 16'd53};
        start = 1'b1;
        step();
        start = 1'b0;
        in_valid = 1'b1;
        in_data  = 16'd20;
        step();
        in_data = 16'd30;
        step();
        in_data = 16'd40;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, out_data, out_first, out_last, busy, done} !== 23'd0) begin
            errors++;
            $display("FAIL async_reset got %h exp 0", {in_ready, out_valid, out_data, out_first, out_last, busy, done});
        end
        step();
        step();
        checks++;
        if ({done, busy, out_valid} !== 3'b000) begin
            errors++;
            $display("FAIL reset_no_done got %b exp 000", {done, busy, out_valid});
        end
        #2;
        rst_n = 1'b1;
        in_valid = 1'b0;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_data  = vin[i];
            step();
            checks++;
            if ({out_valid, out_data, out_first, out_last} !== {1'b1, (i == 0) ? 17'd50 : 17'd1, i == 0, i == 3}) begin
                errors++;
                $display("FAIL reset_restart word%0d got %h exp %h", i, {out_valid, out_data, out_first, out_last}, {1'b1, (i == 0) ? 17'd50 : 17'd1, i == 0, i == 3});
            end
        end
        in_valid = 1'b0;
        step();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL reset_restart done got %b exp 1", done);
        end
        step();
    endtask

`ifdef DELTA_CHECKSUM_EN
    task automatic test_checksum();
        b_out_ready = 1'b1;
        b_start = 1'b1;
        step();
        b_start = 1'b0;
        b_in_valid = 1'b1;
        b_in_data  = 16'hFFFF;
        for (int i = 0; i < 1024; i++) step();
        b_in_valid = 1'b0;
        for (int k = 0; k < 8 && !b_done; k++) step();
        checks++;
        if ({b_done, b_checksum} !== {1'b1, 32'h03FFFC00}) begin
            errors++;
            $display("FAIL checksum got done=%b sum=%h exp done=1 sum=03fffc00", b_done, b_checksum);
        end
        step();
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        start = 1'b0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
`ifdef DELTA_CHECKSUM_EN
        b_start = 1'b0;
        b_in_valid = 1'b0;
        b_in_data = '0;
        b_out_ready = 1'b1;
`endif
        test_reset();
        test_ramp();
        test_negative();
        test_backpressure();
        test_start_ignored();
        test_reset_mid();
`ifdef DELTA_CHECKSUM_EN
        test_checksum();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
